midi_event_framer: RTL
======================

# midi_event_framer

Converts the raw byte stream from the MIDI UART receiver into complete MIDI channel-voice events. It handles running status, interleaved real-time bytes and SysEx. Completed events are buffered in a small FIFO and presented on the valid/ack event interface consumed by the MIDI player's note processor. The block sits between the UART byte receiver and the player, in the main `clk` domain.

## Interface

Parameters:
- `FIFO_DEPTH`, default 4: number of buffered events; must be a power of two, ≥2.
- `NOTE_ON_ZERO_IS_OFF`, default 1: when 1, Note On with velocity 0 is emitted as Note Off (`8n`).

Ports:
- `clk`  in  1  system clock; one clock for the whole block.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `byte_data`  in  8  received UART byte.
- `byte_valid`  in  1  one-cycle strobe; `byte_data` is valid this cycle.
- `midi_event_valid`  out  1  high while the FIFO is non-empty.
- `midi_command`  out  8  status byte of the head event.
- `midi_parameter_1`  out  7  first data byte of the head event.
- `midi_parameter_2`  out  7  second data byte of the head event; 0 for one-data-byte commands.
- `midi_event_ack`  in  1  consumer acknowledge.
- `overflow`  out  1  sticky; set when an event is dropped because the FIFO is full.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  number of buffered events.

## Operation

Byte classification on `byte_valid`:
- `F8`–`FF` (real-time): ignored entirely; parser state, running status and partial data are untouched.
- `80`–`EF` (channel status): latch as running status, discard any partial message, go to WAIT_D1.
- `F0` (SysEx start): clear running status, go to SYSEX.
- `F1`–`F7`: clear running status, go to IDLE. `F7` ends SysEx.
- `00`–`7F` (data): handled per parser state.

Parser states:
- **IDLE**: no running status; data bytes are discarded.
- **WAIT_D1**: a data byte is stored as p1.
  - Commands `Cn` and `Dn` complete immediately with p2=0 and stay in WAIT_D1.
  - All other commands go to WAIT_D2.
- **WAIT_D2**: a data byte is stored as p2, the event completes, and the parser returns to WAIT_D1 (running status retained).
- **SYSEX**: data bytes are discarded. `F7` or any other non-real-time status byte exits SYSEX per the classification above.

Event completion:
- If the command is `9n`, p2==0 and `NOTE_ON_ZERO_IS_OFF`==1, the emitted command is `8n`. Otherwise the emitted command is the running status unchanged.

FIFO push/pop:
- A completed event is pushed if `fifo_level < FIFO_DEPTH`.
- If the FIFO is full, the event is dropped and `overflow` is set; it clears only on reset.
- Pop when `midi_event_valid && midi_event_ack` at a clock edge.
- Push and pop in the same cycle:
  - Both happen and the level is unchanged.
  - When full, the pop frees the slot, so the push is accepted with no overflow.
- `midi_event_ack` while `midi_event_valid` is low has no effect.
- Outputs always show the head entry; they are don't-care (but stable) while empty.
- Read and write pointers wrap modulo `FIFO_DEPTH`.

## Timing

- Reset (async assert, sync release):
  - `midi_event_valid`=0, `midi_command`=0, both parameters=0, `overflow`=0, `fifo_level`=0.
  - Parser in IDLE, running status cleared.
- Asserting reset mid-message or mid-SysEx discards all partial and buffered state.
- Latency: the final data byte is strobed at edge N; the event is visible with `midi_event_valid`=1 after edge N (cycle N+1) when the FIFO was empty.
- Consumer protocol: ack is asserted for one cycle, the cycle after valid is seen.
  - The pop occurs at the edge where valid and ack are both high.
  - The next head (or valid=0) appears the following cycle.
  - Back-to-back events therefore drain at one per two cycles.
- One byte per `byte_valid`; consecutive-cycle strobes must be accepted.

## Test plan

- Basic note: `90 3C 64` → one event: cmd `90`, p1 `3C`, p2 `64`; valid one cycle after the `64` strobe. Ack → valid=0, level=0.
- Running status plus velocity-0 note: `90 3C 64 40 00` → two events: (`90`,`3C`,`64`) then (`80`,`40`,`00`). With `NOTE_ON_ZERO_IS_OFF`=0, the second event is `90`.
- Real-time interleave: `B1 F8 01 FE 7F` → single event (`B1`,`01`,`7F`); parser state is unaffected by `F8` and `FE`.
- One-data-byte commands: `C5 07 09` → events (`C5`,`07`,`00`) and (`C5`,`09`,`00`).
- SysEx and abort:
  - `F0 01 02 F7 3C 40` → no events.
  - `90 3C 92 41 50` → one event (`92`,`41`,`50`).
- Overflow: with no ack, send 5 complete note-ons (depth 4) → level=4, `overflow`=1, and the first four drain in order. Sending a 5th message with simultaneous ack/push while full → accepted, `overflow` stays 0 from a fresh reset.

Source files
------------

// File: rtl/midi_event_framer.sv
// Frames a raw MIDI byte stream into channel-voice events and buffers them in a small FIFO.
// Latency: event visible one cycle after its final data byte; consumer pops with valid&&ack, drops set sticky overflow when full.
module midi_event_framer #(
    parameter int FIFO_DEPTH          = 4,
    parameter bit NOTE_ON_ZERO_IS_OFF = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [7:0]                   byte_data,
    input  logic                         byte_valid,
    output logic                         midi_event_valid,
    output logic [7:0]                   midi_command,
    output logic [6:0]                   midi_parameter_1,
    output logic [6:0]                   midi_parameter_2,
    input  logic                         midi_event_ack,
    output logic                         overflow,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);
    localparam int              PW      = $clog2(FIFO_DEPTH);
    localparam int              LW      = PW + 1;
    localparam logic [LW-1:0]   DEPTH_L = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT_D1, WAIT_D2, SYSEX} state_t;

    state_t         state_q, state_d;
    logic [7:0]     status_q, status_d;
    logic [6:0]     p1_q, p1_d;

    logic           evt_done;
    logic [7:0]     evt_cmd;
    logic [6:0]     evt_p1, evt_p2;

    logic [7:0]     cmd_q [FIFO_DEPTH];
    logic [6:0]     par1_q [FIFO_DEPTH];
    logic [6:0]     par2_q [FIFO_DEPTH];
    logic [PW-1:0]  rd_ptr_q, wr_ptr_q;
    logic [LW-1:0]  level_q;
    logic           overflow_q;
    logic           push, pop;

    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        p1_d     = p1_q;
        evt_done = 1'b0;
        evt_cmd  = status_q;
        evt_p1   = p1_q;
        evt_p2   = 7'd0;
        if (byte_valid) begin
            if (byte_data >= 8'hF8) begin
                // real-time bytes pass through without touching parser state
            end else if (byte_data[7]) begin
                if (byte_data < 8'hF0) begin
                    status_d = byte_data;
                    state_d  = WAIT_D1;
                end else begin
                    status_d = 8'h00;
                    state_d  = (byte_data == 8'hF0) ? SYSEX : IDLE;
                end
            end else begin
                case (state_q)
                    WAIT_D1: begin
                        p1_d = byte_data[6:0];
                        if (status_q[7:5] == 3'b110) begin
                            evt_done = 1'b1;
                            evt_p1   = byte_data[6:0];
                        end else begin
                            state_d = WAIT_D2;
                        end
                    end
                    WAIT_D2: begin
                        evt_done = 1'b1;
                        evt_p2   = byte_data[6:0];
                        state_d  = WAIT_D1;
                        if (NOTE_ON_ZERO_IS_OFF && status_q[7:4] == 4'h9 && byte_data[6:0] == 7'd0)
                            evt_cmd = {4'h8, status_q[3:0]};
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            status_q <= 8'h00;
            p1_q     <= 7'd0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            p1_q     <= p1_d;
        end
    end

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign pop  = midi_event_valid && midi_event_ack;
    assign push = evt_done && ((level_q != DEPTH_L) || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                cmd_q[i]  <= 8'h00;
                par1_q[i] <= 7'd0;
                par2_q[i] <= 7'd0;
            end
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                cmd_q[wr_ptr_q]  <= evt_cmd;
                par1_q[wr_ptr_q] <= evt_p1;
                par2_q[wr_ptr_q] <= evt_p2;
                wr_ptr_q         <= wr_ptr_q + PW'(1);
            end
            if (pop)
                rd_ptr_q <= rd_ptr_q + PW'(1);
            if (push && !pop)
                level_q <= level_q + LW'(1);
            else if (pop && !push)
                level_q <= level_q - LW'(1);
            if (evt_done && !push)
                overflow_q <= 1'b1;
        end
    end

    assign midi_event_valid = (level_q != '0);
    assign midi_command     = cmd_q[rd_ptr_q];
    assign midi_parameter_1 = par1_q[rd_ptr_q];
    assign midi_parameter_2 = par2_q[rd_ptr_q];
    assign overflow         = overflow_q;
    assign fifo_level       = level_q;
endmodule
